pmem_responder: RTL and testbench
=================================

Name: pmem_responder

Overview:
- Synthesizable physical-memory responder: the memory-side end of the cache's pmem_read/pmem_write/pmem_resp line-transfer interface.
- Services one 128-bit line per request from an on-chip line array.
- Fixed, parameterized access latency and a single-cycle pmem_resp pulse.
- Replaces the behavioural memory model so cache_control can be exercised in synthesis and on FPGA.

Parameters:
- LATENCY, 4: cycles from request acceptance to pmem_resp; legal range 1..255.
- INDEX_BITS, 8: line-array index width; array holds 2**INDEX_BITS lines, indexed by pmem_address[INDEX_BITS+3:4].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pmem_read  in  1  line read request; held by initiator until pmem_resp
- pmem_write  in  1  line write request; held by initiator until pmem_resp
- pmem_address  in  16  byte address; bits [3:0] ignored (line aligned)
- pmem_wdata  in  128  write line data
- pmem_rdata  out  128  read line data; valid in the pmem_resp cycle, then held
- pmem_resp  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE, pmem_resp=0, pmem_rdata=0, counter=0.
  - Array contents are not reset.
  - A reset mid-operation aborts it: no array write, no pmem_resp.
- IDLE:
  - On a cycle with pmem_read|pmem_write=1, latch address index, wdata and op into registers.
  - Load counter = LATENCY-1; go to BUSY.
- Simultaneous pmem_read and pmem_write: treated as a write.
- BUSY:
  - Inputs ignored.
  - Counter decrements each cycle; when counter==0 go to RESPOND.
  - Counter is 8 bits; it never underflows.
- RESPOND (one cycle):
  - pmem_resp=1.
  - For a read, pmem_rdata = array[latched index], registered on entry to RESPOND.
  - For a write, array[latched index] <= latched wdata at the end of this cycle.
  - Next state is RECOVER.
- RECOVER (one cycle): inputs ignored, pmem_resp=0; go to IDLE. This gives the initiator one cycle to drop its request.
- Latency: request sampled at edge N gives pmem_resp high in cycle N+LATENCY.
  - LATENCY=1: BUSY is skipped (IDLE goes directly to RESPOND).
  - Back-to-back accepted requests are spaced at least LATENCY+2 cycles apart.
- Request dropped before pmem_resp: the latched operation still completes (the write commits) and pmem_resp still pulses.
- Request still held in the first IDLE cycle after RECOVER: accepted as a new request.
- Write-then-read of the same line: the read returns the newly written data; no bypass is needed because the write commits before RECOVER.
- pmem_rdata holds its last read value through writes and idle cycles.

Optional Feature:
- Macro: PMEM_RESPONDER_STATS_EN.
- When defined, two output ports are added:
  - rd_count: out, 16 bits.
  - wr_count: out, 16 bits.
- Counter behaviour:
  - Each counter increments by 1 in the RESPOND cycle of its op type.
  - Both counters saturate at 16'hFFFF.
  - rst clears both to 0.
- When undefined, the ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
- lc3b_types package gains:
  - typedef lc3b_line (logic [127:0]);
  - enum pmem_state_t {IDLE, BUSY, RESPOND, RECOVER};
  - constant PMEM_LINE_OFFSET_BITS = 4.
- Sub-module pmem_line_array:
  - 2**INDEX_BITS x 128 storage;
  - synchronous write enable;
  - registered read port.
- pmem_responder holds the FSM, latency counter, request latches and optional stats.

Test Plan:
- Write line 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to address 16'h0040, then read address 16'h004C. Required: each pmem_resp pulses exactly 4 cycles after acceptance, and the read returns the same line.
- LATENCY=1 build: read request. Required: pmem_resp in the next cycle; the next accepted request comes no earlier than 3 cycles after the first acceptance.
- pmem_read and pmem_write both high with wdata=128'hAA..AA at address 16'h0100. Required: treated as a write; a later read of 16'h0100 returns 128'hAA..AA.
- Write to 16'h0200, with pmem_write dropped 1 cycle after acceptance. Required: pmem_resp still pulses at +4 and the data commits.
- rst asserted 2 cycles into a write of 128'h55..55 to 16'h0300 (prior content 128'h11..11). Required: no pmem_resp; pmem_rdata=0; a later read returns 128'h11..11.
- STATS_EN build: 3 reads + 2 writes. Required: rd_count=3, wr_count=2.
  - Preload rd_count to 16'hFFFE via force, then do 2 reads. Required: rd_count=16'hFFFF.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared line type, responder state encoding and line geometry
package lc3b_types;
    typedef logic [127:0] lc3b_line;
    typedef enum logic [1:0] {IDLE, BUSY, RESPOND, RECOVER} pmem_state_t;
    localparam int PMEM_LINE_OFFSET_BITS = 4;
endpackage

// File: rtl/pmem_line_array.sv
// pmem_line_array: line storage with synchronous write and registered read port
module pmem_line_array
    import lc3b_types::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_waddr,
    input  lc3b_line              i_wdata,
    input  logic                  i_re,
    input  logic [INDEX_BITS-1:0] i_raddr,
    output lc3b_line              o_rdata
);
    lc3b_line r_mem [2**INDEX_BITS];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency line memory behind pmem_read/pmem_write/pmem_resp; PMEM_RESPONDER_STATS_EN adds rd_count/wr_count
module pmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [15:0] pmem_address,
    input  lc3b_line    pmem_wdata,
    output lc3b_line    pmem_rdata,
    output logic        pmem_resp
`ifdef PMEM_RESPONDER_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);
    pmem_state_t           r_state;
    logic [7:0]            r_count;
    logic [INDEX_BITS-1:0] r_idx;
    lc3b_line              r_wdata;
    logic                  r_write;
    logic                  w_req, w_to_resp, w_re, w_we, w_unused;
    logic [INDEX_BITS-1:0] w_in_idx, w_raddr;
    logic [7:0]            w_count_nxt;
    assign w_unused = ^pmem_address;
    always_comb begin
        w_req       = pmem_read | pmem_write;
        w_in_idx    = pmem_address[INDEX_BITS+PMEM_LINE_OFFSET_BITS-1:PMEM_LINE_OFFSET_BITS];
        w_count_nxt = r_count - 8'd1;
        w_to_resp   = (r_state == IDLE && w_req && LATENCY == 1) || (r_state == BUSY && w_count_nxt == 8'd0);
        w_raddr     = (r_state == IDLE) ? w_in_idx : r_idx;
        // the read is launched one cycle early so the registered array output lands on RESPOND entry
        w_re        = w_to_resp && !((r_state == IDLE) ? pmem_write : r_write) && !rst;
        w_we        = r_state == RESPOND && r_write && !rst;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            pmem_resp <= 1'b0;
        end else begin
            pmem_resp <= w_to_resp;
            unique case (r_state)
                IDLE: if (w_req) begin
                    r_idx   <= w_in_idx;
                    r_wdata <= pmem_wdata;
                    r_write <= pmem_write;
                    r_count <= 8'(LATENCY - 1);
                    r_state <= (LATENCY == 1) ? RESPOND : BUSY;
                end
                BUSY: begin
                    r_count <= w_count_nxt;
                    if (w_count_nxt == 8'd0) r_state <= RESPOND;
                end
                RESPOND: r_state <= RECOVER;
                default: r_state <= IDLE;
            endcase
        end
    end
    pmem_line_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_we),
        .i_waddr(r_idx),
        .i_wdata(r_wdata),
        .i_re   (w_re),
        .i_raddr(w_raddr),
        .o_rdata(pmem_rdata)
    );
`ifdef PMEM_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (r_state == RESPOND) begin
            if (r_write && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (!r_write && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: transaction-level model check of pmem_responder plus directed latency/data cases
module tb_pmem_responder;
    import lc3b_types::*;
    localparam int LAT = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pmem_read = 1'b0, pmem_write = 1'b0;
    logic [15:0] pmem_address = '0;
    lc3b_line    pmem_wdata = '0;
    lc3b_line    pmem_rdata;
    logic        pmem_resp;
    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [15:0] a1 = '0;
    lc3b_line    d1 = '0;
    lc3b_line    rdata1;
    logic        resp1;
`ifdef PMEM_RESPONDER_STATS_EN
    logic [15:0] rd_count, wr_count, rdc1, wrc1;
`endif
    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;
    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(LAT), .INDEX_BITS(8)) dut (
        .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef PMEM_RESPONDER_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );
    pmem_responder #(.LATENCY(1), .INDEX_BITS(8)) dut1 (
        .clk(clk), .rst(rst), .pmem_read(rd1), .pmem_write(wr1),
        .pmem_address(a1), .pmem_wdata(d1),
        .pmem_rdata(rdata1), .pmem_resp(resp1)
`ifdef PMEM_RESPONDER_STATS_EN
        , .rd_count(rdc1), .wr_count(wrc1)
`endif
    );

    // transaction model: one op in flight, accepted when the responder is free again
    int       cyc = 0, free_at = 0, resp_at = 0;
    logic     pend = 1'b0, p_wr = 1'b0;
    logic [7:0] p_idx = '0;
    lc3b_line p_data = '0;
    lc3b_line m_mem [256];
    logic     m_resp = 1'b0;
    lc3b_line m_rdata = '0;
    int       m_rd_done = 0, m_wr_done = 0, rd_off = 0;

    always @(posedge clk) begin
        cyc++;
        m_resp = 1'b0;
        if (rst) begin
            pend = 1'b0;
            free_at = cyc + 1;
            m_rdata = '0;
            m_rd_done = 0;
            m_wr_done = 0;
        end else begin
            if (pend && cyc == resp_at + 1) begin
                if (p_wr) begin
                    m_mem[p_idx] = p_data;
                    m_wr_done++;
                end else m_rd_done++;
                pend = 1'b0;
            end
            if ((pmem_read || pmem_write) && cyc >= free_at) begin
                pend = 1'b1;
                p_wr = pmem_write;
                p_idx = pmem_address[11:4];
                p_data = pmem_wdata;
                resp_at = cyc + LAT - 1;
                free_at = cyc + LAT + 2;
            end
            if (pend && cyc == resp_at) begin
                m_resp = 1'b1;
                if (!p_wr) m_rdata = m_mem[p_idx];
            end
        end
    end

    function automatic logic [15:0] sat(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (pmem_resp !== m_resp) begin
                miscompares++;
                $display("FAIL resp cyc=%0d: dut=%b model=%b", cyc, pmem_resp, m_resp);
            end
            vectors++;
            if (pmem_rdata !== m_rdata) begin
                miscompares++;
                $display("FAIL rdata cyc=%0d: dut=%h model=%h", cyc, pmem_rdata, m_rdata);
            end
`ifdef PMEM_RESPONDER_STATS_EN
            vectors++;
            if (rd_count !== sat(rd_off + m_rd_done)) begin
                miscompares++;
                $display("FAIL rd_count cyc=%0d: dut=%h model=%h", cyc, rd_count, sat(rd_off + m_rd_done));
            end
            vectors++;
            if (wr_count !== sat(m_wr_done)) begin
                miscompares++;
                $display("FAIL wr_count cyc=%0d: dut=%h model=%h", cyc, wr_count, sat(m_wr_done));
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // issue one op from an IDLE negedge; lat = samples from acceptance to pmem_resp (0 = never)
    task automatic op(input logic r, input logic w, input logic [15:0] a, input lc3b_line d,
                      input int drop, output int lat);
        pmem_read = r;
        pmem_write = w;
        pmem_address = a;
        pmem_wdata = d;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == drop) begin
                pmem_read = 1'b0;
                pmem_write = 1'b0;
            end
            if (pmem_resp) begin
                lat = n;
                break;
            end
        end
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat, first, second, k;
        logic seen;
        lc3b_line line_a, line_d, line_x;
        line_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        line_d = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        line_x = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0;
        repeat (3) @(negedge clk);
        chk("reset_resp", 128'(pmem_resp), 128'd0);
        chk("reset_rdata", pmem_rdata, 128'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        op(1'b0, 1'b1, 16'h0040, line_a, 0, lat);
        chk("wr_latency", 128'(lat), 128'd4);
        op(1'b1, 1'b0, 16'h004C, '0, 0, lat);
        chk("rd_latency", 128'(lat), 128'd4);
        chk("rd_after_wr", pmem_rdata, line_a);

        op(1'b1, 1'b1, 16'h0100, {16{8'hAA}}, 0, lat);
        chk("both_latency", 128'(lat), 128'd4);
        chk("both_rdata_held", pmem_rdata, line_a);
        op(1'b1, 1'b0, 16'h0100, '0, 0, lat);
        chk("both_is_write", pmem_rdata, {16{8'hAA}});

        op(1'b0, 1'b1, 16'h0200, line_d, 1, lat);
        chk("drop_latency", 128'(lat), 128'd4);
        op(1'b1, 1'b0, 16'h0200, '0, 0, lat);
        chk("drop_committed", pmem_rdata, line_d);

        op(1'b0, 1'b1, 16'h0300, {16{8'h11}}, 0, lat);
        chk("hold_through_wr", pmem_rdata, line_d);
        pmem_write = 1'b1;
        pmem_address = 16'h0300;
        pmem_wdata = {16{8'h55}};
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pmem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | pmem_resp;
        end
        chk("abort_no_resp", 128'(seen), 128'd0);
        chk("abort_rdata", pmem_rdata, 128'd0);
        op(1'b1, 1'b0, 16'h0300, '0, 0, lat);
        chk("abort_no_commit", pmem_rdata, {16{8'h11}});

        wr1 = 1'b1;
        a1 = 16'h0050;
        d1 = line_x;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (resp1) begin
                lat = n;
                break;
            end
        end
        wr1 = 1'b0;
        chk("lat1_wr_latency", 128'(lat), 128'd1);
        repeat (2) @(negedge clk);
        rd1 = 1'b1;
        first = 0;
        second = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (resp1) begin
                if (first == 0) first = n;
                else if (second == 0) second = n;
            end
        end
        rd1 = 1'b0;
        chk("lat1_rd_latency", 128'(first), 128'd1);
        chk("lat1_spacing", 128'(second - first), 128'd3);
        chk("lat1_rdata", rdata1, line_x);

        for (int i = 0; i < 16; i++)
            op(1'b0, 1'b1, 16'h0800 + 16'(i * 16), {$urandom, $urandom, $urandom, $urandom}, 0, lat);
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 3);
                pmem_read = (k == 1 || k == 3);
                pmem_write = (k >= 2);
                pmem_address = {4'($urandom), 4'h8, 4'($urandom_range(0, 15)), 4'($urandom)};
                pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        repeat (8) @(negedge clk);

`ifdef PMEM_RESPONDER_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) op(1'b1, 1'b0, 16'h0800, '0, 0, lat);
        repeat (2) op(1'b0, 1'b1, 16'h0810, line_x, 0, lat);
        chk("stats_rd3", 128'(rd_count), 128'd3);
        chk("stats_wr2", 128'(wr_count), 128'd2);
        @(posedge clk);
        #1;
        force dut.rd_count = 16'hFFFE;
        rd_off = 32'hFFFE - m_rd_done;
        @(posedge clk);
        #1;
        release dut.rd_count;
        @(negedge clk);
        repeat (2) op(1'b1, 1'b0, 16'h0800, '0, 0, lat);
        chk("stats_rd_sat", 128'(rd_count), 128'hFFFF);
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
